elixirchip_es1_spu_xor_fold: RTL and testbench
==============================================

ELIXIRCHIP_ES1_SPU_XOR_FOLD -- requirements
Module: elixirchip_es1_spu_xor_fold

Interface
REQ-001 Parameter DATA_BITS, default 8, width of s_data and m_data.
REQ-002 Parameter COUNT_BITS, default 8, width of m_count.
REQ-003 Parameter CLEAR_DATA, default all-0 (DATA_BITS wide), accumulator seed at frame start.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Port cke  input  1  clock enable; when 0, every register holds, outputs included.
REQ-007 Port s_data  input  DATA_BITS  word from the upstream XOR op stage.
REQ-008 Port s_valid  input  1  s_data is a valid beat.
REQ-009 Port s_first  input  1  beat starts a frame; qualified by s_valid.
REQ-010 Port s_last  input  1  beat ends a frame; qualified by s_valid.
REQ-011 Port s_clear  input  1  synchronous abort of the current frame; ignores s_valid.
REQ-012 Port m_data  output  DATA_BITS  XOR fold of the completed frame.
REQ-013 Port m_count  output  COUNT_BITS  beat count of the completed frame, saturating.
REQ-014 Port m_valid  output  1  m_data, m_count and m_overflow are valid; one-beat pulse.
REQ-015 Port m_overflow  output  1  the frame held more than 2^COUNT_BITS-1 beats.
REQ-016 Port m_abort  output  1  one-beat pulse; an open frame was discarded by a restart.

Function
REQ-017 The block SHALL update state only on a rising edge of clk with cke=1 (an "active edge"); the rules below refer only to active edges.
REQ-018 The block SHALL have two states: IDLE (no frame open) and ACC (frame open). An internal accumulator acc and beat counter cnt SHALL be held.
REQ-019 In IDLE, a beat (s_valid=1) SHALL start a frame: acc<=CLEAR_DATA^s_data, cnt<=1. s_first is ignored, so a frame starts implicitly.
REQ-020 In IDLE, if that beat also has s_last=1, the block SHALL emit it as a single-beat frame (REQ-023) and stay in IDLE; otherwise it SHALL go to ACC.
REQ-021 In ACC, a beat with s_first=0 SHALL set acc<=acc^s_data, cnt<=cnt+1; cnt SHALL saturate at 2^COUNT_BITS-1 and set a per-frame overflow flag.
REQ-022 In ACC, a beat with s_first=1 SHALL discard the open frame: m_abort=1 for one active edge, then restart per REQ-019/020.
REQ-023 A beat with s_last=1 SHALL end the frame, on the active edge that samples it:
- m_data <= fold including that beat
- m_count <= count including that beat
- m_overflow <= overflow flag
- m_valid <= 1
- state <= IDLE
Latency from s_last beat to m_valid SHALL be 1 active edge.
REQ-024 On an active edge that emits no frame, m_valid SHALL be 0 and m_abort SHALL be 0. m_data, m_count and m_overflow SHALL hold their last emitted values.
REQ-025 s_valid=0 SHALL leave acc, cnt and state unchanged.
REQ-026 s_clear=1 SHALL take priority over any beat on the same edge:
- state <= IDLE, acc <= CLEAR_DATA, cnt <= 0, overflow flag cleared
- m_valid <= 0, m_abort <= 0
- no frame is emitted
REQ-027 With cke=0, m_valid and m_abort SHALL remain at their current value; the downstream stage samples them under the same cke.
REQ-028 The fold SHALL be a bitwise XOR; no carries and no width growth.

Reset
REQ-029 While reset_n=0, the block SHALL asynchronously force:
- state=IDLE, acc=CLEAR_DATA, cnt=0
- m_data=0, m_count=0, m_valid=0, m_overflow=0, m_abort=0
This SHALL be independent of clk and cke.
REQ-030 After reset_n deasserts, the first active edge SHALL be handled as IDLE. A frame open at reset assertion SHALL be lost without any output.

Verification
REQ-031 Multi-beat frame: beats 0x0F(first), 0xF0, 0xFF(last) with CLEAR_DATA=0 -> m_data=0x00, m_count=3, m_valid high for exactly 1 active edge.
REQ-032 Single beat and cke stalls:
- 0xA5 with first and last together -> m_data=0xA5, m_count=1.
- Repeat REQ-031 with cke=0 for 3 cycles between beats -> same result; m_valid stays high while cke=0.
REQ-033 Restart mid-frame: 0x11(first), 0x22(first), 0x44(last) -> m_abort pulse after the second beat; then m_data=0x66, m_count=2.
REQ-034 Clear: s_clear=1 together with s_last beat 0x33 mid-frame -> no m_valid; next frame 0x01(first,last) -> m_data=0x01, m_count=1.
REQ-035 Reset and overflow:
- reset_n low mid-frame, between clock edges -> all outputs 0 at once; next frame is correct.
- COUNT_BITS=2, 5-beat frame -> m_count=3, m_overflow=1.

Source files
------------

// File: rtl/elixirchip_es1_spu_xor_fold.sv
// Frame-level XOR fold for the SPU XOR op stage: folds every beat of a frame into
// one word and reports the saturating beat count, overflow and restart aborts.
module elixirchip_es1_spu_xor_fold #(
  parameter int unsigned          DATA_BITS  = 8,
  parameter int unsigned          COUNT_BITS = 8,
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,
  input  logic [DATA_BITS-1:0]  s_data,
  input  logic                  s_valid,
  input  logic                  s_first,
  input  logic                  s_last,
  input  logic                  s_clear,
  output logic [DATA_BITS-1:0]  m_data,
  output logic [COUNT_BITS-1:0] m_count,
  output logic                  m_valid,
  output logic                  m_overflow,
  output logic                  m_abort
);

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_BITS-1:0]    acc_q, acc_d;
  logic [COUNT_BITS-1:0]   cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;

  logic [DATA_BITS-1:0]    data_d;
  logic [COUNT_BITS-1:0]   count_d;
  logic                    overflow_d;
  logic                    valid_d;
  logic                    abort_d;

  // Frame contents after folding in the current beat (fresh or continued).
  logic [DATA_BITS-1:0]    f_acc;
  logic [COUNT_BITS-1:0]   f_cnt;
  logic                    f_ovf;

  // Next-state and output decode; a cleared or idle edge drops the pulses.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    data_d     = m_data;
    count_d    = m_count;
    overflow_d = m_overflow;
    valid_d    = 1'b0;
    abort_d    = 1'b0;
    f_acc      = CLEAR_DATA ^ s_data;
    f_cnt      = COUNT_BITS'(1);
    f_ovf      = 1'b0;

    if (s_clear) begin
      state_d = ST_IDLE;
      acc_d   = CLEAR_DATA;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (s_valid) begin
      if (state_q == ST_ACC) begin
        if (s_first) begin
          abort_d = 1'b1;
        end else begin
          f_acc = acc_q ^ s_data;
          f_cnt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNT_BITS'(1);
          f_ovf = ovf_q | (cnt_q == CNT_MAX);
        end
      end

      if (s_last) begin
        valid_d    = 1'b1;
        data_d     = f_acc;
        count_d    = f_cnt;
        overflow_d = f_ovf;
        state_d    = ST_IDLE;
        acc_d      = CLEAR_DATA;
        cnt_d      = '0;
        ovf_d      = 1'b0;
      end else begin
        state_d = ST_ACC;
        acc_d   = f_acc;
        cnt_d   = f_cnt;
        ovf_d   = f_ovf;
      end
    end
  end

  // All state and outputs advance only on enabled edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= CLEAR_DATA;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      m_data     <= '0;
      m_count    <= '0;
      m_valid    <= 1'b0;
      m_overflow <= 1'b0;
      m_abort    <= 1'b0;
    end else if (cke) begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      m_data     <= data_d;
      m_count    <= count_d;
      m_valid    <= valid_d;
      m_overflow <= overflow_d;
      m_abort    <= abort_d;
    end
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_xor_fold.sv
// Bench for the XOR fold: directed frame scenarios plus random traffic checked
// against a queue-based frame model, on a default instance and a 2-bit-count one.
module tb_elixirchip_es1_spu_xor_fold;

  localparam logic [7:0] CLEAR_B = 8'h5A;

  logic       clk;
  logic       reset_n;
  logic       cke;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_first;
  logic       s_last;
  logic       s_clear;

  logic [7:0] m_data_a;
  logic [7:0] m_count_a;
  logic       m_valid_a;
  logic       m_overflow_a;
  logic       m_abort_a;

  logic [7:0] m_data_b;
  logic [1:0] m_count_b;
  logic       m_valid_b;
  logic       m_overflow_b;
  logic       m_abort_b;

  elixirchip_es1_spu_xor_fold dut_a (
    .clk(clk), .reset_n(reset_n), .cke(cke),
    .s_data(s_data), .s_valid(s_valid), .s_first(s_first), .s_last(s_last), .s_clear(s_clear),
    .m_data(m_data_a), .m_count(m_count_a), .m_valid(m_valid_a),
    .m_overflow(m_overflow_a), .m_abort(m_abort_a)
  );

  elixirchip_es1_spu_xor_fold #(
    .DATA_BITS(8), .COUNT_BITS(2), .CLEAR_DATA(CLEAR_B)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .cke(cke),
    .s_data(s_data), .s_valid(s_valid), .s_first(s_first), .s_last(s_last), .s_clear(s_clear),
    .m_data(m_data_b), .m_count(m_count_b), .m_valid(m_valid_b),
    .m_overflow(m_overflow_b), .m_abort(m_abort_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the open frame is just the list of its beats.
  logic [7:0] frame_q[$];
  bit         open = 0;
  logic [7:0] e_data_a = '0;
  logic [7:0] e_cnt_a  = '0;
  logic       e_ovf_a  = 1'b0;
  logic [7:0] e_data_b = '0;
  logic [1:0] e_cnt_b  = '0;
  logic       e_ovf_b  = 1'b0;
  logic       e_valid  = 1'b0;
  logic       e_abort  = 1'b0;

  task automatic model_edge(input logic [7:0] d, input logic v, f, l, clr, ck);
    logic [7:0] x;
    int n;
    if (!ck) return;
    e_valid = 1'b0;
    e_abort = 1'b0;
    if (clr) begin
      frame_q.delete();
      open = 0;
    end else if (v) begin
      if (open && f) begin
        e_abort = 1'b1;
        frame_q.delete();
      end
      frame_q.push_back(d);
      open = 1;
      if (l) begin
        x = '0;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        n = frame_q.size();
        e_data_a = x;
        e_data_b = CLEAR_B ^ x;
        e_cnt_a  = (n > 255) ? 8'd255 : 8'(n);
        e_ovf_a  = (n > 255);
        e_cnt_b  = (n > 3) ? 2'd3 : 2'(n);
        e_ovf_b  = (n > 3);
        e_valid  = 1'b1;
        frame_q.delete();
        open = 0;
      end
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    open = 0;
    e_data_a = '0; e_cnt_a = '0; e_ovf_a = 1'b0;
    e_data_b = '0; e_cnt_b = '0; e_ovf_b = 1'b0;
    e_valid = 1'b0; e_abort = 1'b0;
  endtask

  task automatic step(input logic [7:0] d, input logic v, f, l, clr, ck);
    s_data = d; s_valid = v; s_first = f; s_last = l; s_clear = clr; cke = ck;
    @(posedge clk);
    #1;
    model_edge(d, v, f, l, clr, ck);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({m_data_a, m_count_a, m_valid_a, m_overflow_a, m_abort_a} !== 19'd0) begin n_fail++; $display("FAIL reset_a got %h exp 0", {m_data_a, m_count_a, m_valid_a, m_overflow_a, m_abort_a}); end
    n_checks++; if ({m_data_b, m_count_b, m_valid_b, m_overflow_b, m_abort_b} !== 13'd0) begin n_fail++; $display("FAIL reset_b got %h exp 0", {m_data_b, m_count_b, m_valid_b, m_overflow_b, m_abort_b}); end
    #2 reset_n = 1'b1;
  endtask

  task automatic test_multi_beat();
    step(8'h0F, 1, 1, 0, 0, 1);
    n_checks++; if (m_valid_a !== 1'b0) begin n_fail++; $display("FAIL multi_early_valid got %b exp 0", m_valid_a); end
    step(8'hF0, 1, 0, 0, 0, 1);
    step(8'hFF, 1, 0, 1, 0, 1);
    n_checks++; if (m_valid_a !== 1'b1) begin n_fail++; $display("FAIL multi_valid got %b exp 1", m_valid_a); end
    n_checks++; if (m_data_a !== 8'h00) begin n_fail++; $display("FAIL multi_data got %h exp 00", m_data_a); end
    n_checks++; if (m_count_a !== 8'd3) begin n_fail++; $display("FAIL multi_count got %0d exp 3", m_count_a); end
    n_checks++; if ({m_data_b, m_count_b, m_overflow_b} !== {8'h5A, 2'd3, 1'b0}) begin n_fail++; $display("FAIL multi_b got %h/%0d/%b exp 5a/3/0", m_data_b, m_count_b, m_overflow_b); end
    step(8'h00, 0, 0, 0, 0, 1);
    n_checks++; if (m_valid_a !== 1'b0) begin n_fail++; $display("FAIL multi_pulse got %b exp 0", m_valid_a); end
    n_checks++; if (m_count_a !== 8'd3) begin n_fail++; $display("FAIL multi_hold_count got %0d exp 3", m_count_a); end
  endtask

  task automatic test_single_beat();
    step(8'hA5, 1, 1, 1, 0, 1);
    n_checks++; if ({m_valid_a, m_data_a, m_count_a} !== {1'b1, 8'hA5, 8'd1}) begin n_fail++; $display("FAIL single got %b/%h/%0d exp 1/a5/1", m_valid_a, m_data_a, m_count_a); end
  endtask

  task automatic test_cke_stall();
    step(8'h0F, 1, 1, 0, 0, 1);
    repeat (3) step(8'hAA, 1, 0, 1, 0, 0);
    step(8'hF0, 1, 0, 0, 0, 1);
    repeat (3) step(8'h55, 1, 1, 1, 1, 0);
    step(8'hFF, 1, 0, 1, 0, 1);
    n_checks++; if ({m_valid_a, m_data_a, m_count_a} !== {1'b1, 8'h00, 8'd3}) begin n_fail++; $display("FAIL stall_result got %b/%h/%0d exp 1/00/3", m_valid_a, m_data_a, m_count_a); end
    for (int i = 0; i < 3; i++) begin
      step(8'h77, 1, 1, 1, 0, 0);
      n_checks++; if ({m_valid_a, m_data_a} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL stall_hold_valid got %b/%h exp 1/00", m_valid_a, m_data_a); end
    end
    step(8'h00, 0, 0, 0, 0, 1);
    n_checks++; if (m_valid_a !== 1'b0) begin n_fail++; $display("FAIL stall_release got %b exp 0", m_valid_a); end
  endtask

  task automatic test_restart();
    step(8'h11, 1, 1, 0, 0, 1);
    step(8'h22, 1, 1, 0, 0, 1);
    n_checks++; if ({m_abort_a, m_valid_a, m_abort_b} !== 3'b101) begin n_fail++; $display("FAIL restart_abort got %b exp 101", {m_abort_a, m_valid_a, m_abort_b}); end
    step(8'h44, 1, 0, 1, 0, 1);
    n_checks++; if ({m_abort_a, m_valid_a, m_data_a, m_count_a} !== {1'b0, 1'b1, 8'h66, 8'd2}) begin n_fail++; $display("FAIL restart_frame got %b/%b/%h/%0d exp 0/1/66/2", m_abort_a, m_valid_a, m_data_a, m_count_a); end
    n_checks++; if (m_data_b !== 8'h3C) begin n_fail++; $display("FAIL restart_seed_b got %h exp 3c", m_data_b); end
  endtask

  task automatic test_clear();
    step(8'h10, 1, 1, 0, 0, 1);
    step(8'h33, 1, 0, 1, 1, 1);
    n_checks++; if ({m_valid_a, m_abort_a} !== 2'b00) begin n_fail++; $display("FAIL clear_no_emit got %b exp 00", {m_valid_a, m_abort_a}); end
    step(8'h01, 1, 1, 1, 0, 1);
    n_checks++; if ({m_valid_a, m_abort_a, m_data_a, m_count_a} !== {2'b10, 8'h01, 8'd1}) begin n_fail++; $display("FAIL clear_next got %b/%b/%h/%0d exp 1/0/01/1", m_valid_a, m_abort_a, m_data_a, m_count_a); end
  endtask

  task automatic test_async_reset();
    step(8'hA5, 1, 1, 1, 0, 1);
    step(8'h12, 1, 1, 0, 0, 1);
    step(8'h34, 1, 0, 0, 0, 1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if ({m_data_a, m_count_a, m_valid_a, m_overflow_a, m_abort_a} !== 19'd0) begin n_fail++; $display("FAIL async_reset_a got %h exp 0", {m_data_a, m_count_a, m_valid_a, m_overflow_a, m_abort_a}); end
    n_checks++; if ({m_data_b, m_count_b, m_valid_b, m_overflow_b, m_abort_b} !== 13'd0) begin n_fail++; $display("FAIL async_reset_b got %h exp 0", {m_data_b, m_count_b, m_valid_b, m_overflow_b, m_abort_b}); end
    reset_n = 1'b1;
    step(8'h56, 1, 0, 1, 0, 1);
    n_checks++; if ({m_valid_a, m_data_a, m_count_a} !== {1'b1, 8'h56, 8'd1}) begin n_fail++; $display("FAIL after_reset got %b/%h/%0d exp 1/56/1", m_valid_a, m_data_a, m_count_a); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++) step(8'(1 << k), 1, k == 0, k == 4, 0, 1);
    n_checks++; if ({m_count_b, m_overflow_b, m_data_b} !== {2'd3, 1'b1, 8'h45}) begin n_fail++; $display("FAIL ovf_b got %0d/%b/%h exp 3/1/45", m_count_b, m_overflow_b, m_data_b); end
    n_checks++; if ({m_count_a, m_overflow_a, m_data_a} !== {8'd5, 1'b0, 8'h1F}) begin n_fail++; $display("FAIL ovf_a_short got %0d/%b/%h exp 5/0/1f", m_count_a, m_overflow_a, m_data_a); end
    step(8'h09, 1, 1, 1, 0, 1);
    n_checks++; if ({m_count_b, m_overflow_b} !== {2'd1, 1'b0}) begin n_fail++; $display("FAIL ovf_clears got %0d/%b exp 1/0", m_count_b, m_overflow_b); end
    for (int k = 0; k < 255; k++) step(8'($urandom), 1, k == 0, k == 254, 0, 1);
    n_checks++; if ({m_count_a, m_overflow_a} !== {8'd255, 1'b0}) begin n_fail++; $display("FAIL ovf_255 got %0d/%b exp 255/0", m_count_a, m_overflow_a); end
    n_checks++; if (m_data_a !== e_data_a) begin n_fail++; $display("FAIL ovf_255_data got %h exp %h", m_data_a, e_data_a); end
    for (int k = 0; k < 256; k++) step(8'($urandom), 1, k == 0, k == 255, 0, 1);
    n_checks++; if ({m_count_a, m_overflow_a} !== {8'd255, 1'b1}) begin n_fail++; $display("FAIL ovf_256 got %0d/%b exp 255/1", m_count_a, m_overflow_a); end
    n_checks++; if (m_data_a !== e_data_a) begin n_fail++; $display("FAIL ovf_256_data got %h exp %h", m_data_a, e_data_a); end
  endtask

  task automatic test_random();
    logic [18:0] got_a, exp_a;
    logic [12:0] got_b, exp_b;
    for (int i = 0; i < 3000; i++) begin
      step(8'($urandom),
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 85);
      got_a = {m_data_a, m_count_a, m_valid_a, m_overflow_a, m_abort_a};
      exp_a = {e_data_a, e_cnt_a, e_valid, e_ovf_a, e_abort};
      got_b = {m_data_b, m_count_b, m_valid_b, m_overflow_b, m_abort_b};
      exp_b = {e_data_b, e_cnt_b, e_valid, e_ovf_b, e_abort};
      n_checks++; if (got_a !== exp_a) begin n_fail++; $display("FAIL random_a cycle %0d got %h exp %h", i, got_a, exp_a); end
      n_checks++; if (got_b !== exp_b) begin n_fail++; $display("FAIL random_b cycle %0d got %h exp %h", i, got_b, exp_b); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cke     = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    s_first = 1'b0;
    s_last  = 1'b0;
    s_clear = 1'b0;
    test_reset();
    test_multi_beat();
    test_single_beat();
    test_cke_stall();
    test_restart();
    test_clear();
    test_async_reset();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
